// File: rtl/file_param_arbiter_pkg.sv
// Purpose : shared types and file-level defaults for the round-robin resource arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: state_e (IDLE/GRANT/RELEASE), default requester count and hold limit.
package file_param_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_e;

   localparam int FPA_NUM_REQ  = 4;
   localparam int FPA_HOLD_MAX = 15;

endpackage

// File: rtl/file_param_arbiter_rr_pick.sv
// Purpose : combinational rotating-priority picker; first set req bit above last_id, wrapping.
// Latency : zero cycles (pure combinational).
// Backpressure: none; result is valid whenever any_o is high.
// Ports   : req_i request vector, last_id_i previous winner index,
//           winner_o one-hot winner, winner_id_o winner index, any_o any request present.
module rr_pick
   import file_param_arbiter_pkg::*;
#(
   parameter  int NUM_REQ = FPA_NUM_REQ,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      last_id_i,
   output logic [NUM_REQ-1:0] winner_o,
   output logic [IW-1:0]      winner_id_o,
   output logic               any_o
);

   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] upper_req;
   logic [NUM_REQ-1:0] cand;

   // Bits strictly above the previous winner get first look.
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_mask[i] = (i > int'(last_id_i));
      end
   end

   assign upper_req = req_i & upper_mask;

   // Nothing above the previous winner: wrap and search from bit 0.
   assign cand = (|upper_req) ? upper_req : req_i;

   // Isolate the lowest set bit of the candidate set.
   assign winner_o = cand & (~cand + NUM_REQ'(1));

   always_comb begin
      winner_id_o = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (cand[i]) begin
            winner_id_o = IW'(i);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/file_param_arbiter.sv
// Purpose : round-robin arbiter granting one requester at a time, with bounded hold time.
// Latency : grant registered one cycle after req seen in IDLE; two gnt-low cycles between grants.
// Backpressure: owner holds until done, req drop, or HOLD_MAX cycles (then a timeout pulse).
// Ports   : clk/rst_n, req per requester, done from owner; gnt one-hot, gnt_valid, gnt_id, timeout.
module file_param_arbiter
   import file_param_arbiter_pkg::*;
#(
   parameter  int NUM_REQ  = FPA_NUM_REQ,
   parameter  int HOLD_MAX = FPA_HOLD_MAX,
   localparam int IW       = $clog2(NUM_REQ),
   localparam int HW       = $clog2(HOLD_MAX + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_valid,
   output logic [IW-1:0]      gnt_id,
   output logic               timeout
);

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]      gnt_id_q, gnt_id_d;
   logic [IW-1:0]      last_id_q, last_id_d;
   logic [HW-1:0]      hold_q, hold_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_id;
   logic               pick_any;
   logic               owner_req;
   logic               release_req;
   logic               at_max;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req_i       (req),
      .last_id_i   (last_id_q),
      .winner_o    (pick_gnt),
      .winner_id_o (pick_id),
      .any_o       (pick_any)
   );

   // Owner's own request bit; other requesters' bits never affect an active grant.
   assign owner_req   = |(req & gnt_q);
   assign release_req = done || !owner_req;
   assign at_max      = (hold_q == HW'(HOLD_MAX));

   // Voluntary release takes precedence, so timeout only flags a forced revoke.
   // Driven during the last grant cycle so it lines up with the final gnt beat.
   assign timeout = (state_q == GRANT) && at_max && !release_req;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      last_id_d = last_id_q;
      hold_d    = hold_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d   = GRANT;
               gnt_d     = pick_gnt;
               gnt_id_d  = pick_id;
               last_id_d = pick_id;
               hold_d    = HW'(1);
            end
         end
         GRANT: begin
            if (release_req || at_max) begin
               state_d  = RELEASE;
               gnt_d    = '0;
               gnt_id_d = '0;
               hold_d   = '0;
            end else begin
               // Never reached with hold_q at HOLD_MAX, so this saturates by construction.
               hold_d = hold_q + HW'(1);
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         last_id_q <= IW'(NUM_REQ - 1);
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         last_id_q <= last_id_d;
         hold_q    <= hold_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = |gnt_q;
   assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_file_param_arbiter.sv
// Purpose : directed self-checking bench for file_param_arbiter (NUM_REQ=4, HOLD_MAX=15).
// Latency : inputs driven 1 time unit after posedge; outputs sampled after settling.
// Backpressure: n/a.
module tb_file_param_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic       timeout;

   int checks;
   int failures;

   file_param_arbiter #(
      .NUM_REQ  (4),
      .HOLD_MAX (15)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Structural invariants every cycle: one-hot grant, valid matches OR, timeout only while granted.
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(gnt) || (gnt_valid !== (|gnt)) || (timeout && !gnt_valid)) begin
         failures++;
         $display("FAIL onehot_monitor t=%0t gnt=%b gnt_valid=%b timeout=%b", $time, gnt, gnt_valid, timeout);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded time limit");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      req   = 4'b0000;
      done  = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
      checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", gnt_valid); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", gnt_id); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      req = 4'b0001;
      #1;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_same_cycle got=%b exp=0000", gnt); end
      step();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt1 got=%b exp=0001", gnt); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", gnt_id); end
      checks++; if (gnt_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", gnt_valid); end
      step();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt2 got=%b exp=0001", gnt); end
      step();
      done = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt3 got=%b exp=0001", gnt); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL single_timeout got=%b exp=0", timeout); end
      step();
      done = 1'b0;
      req  = 4'b0000;
      #1;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_release got=%b exp=0000", gnt); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL single_release_id got=%0d exp=0", gnt_id); end
      step();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_idle got=%b exp=0000", gnt); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      step();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'b0001 << (k % 4);
         step();
         checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt k=%0d got=%b exp=%b", k, gnt, exp_gnt); end
         checks++; if (gnt_id !== 2'(k % 4)) begin failures++; $display("FAIL rr_id k=%0d got=%0d exp=%0d", k, gnt_id, k % 4); end
         done = 1'b1;
         step();
         done = 1'b0;
         #1;
         checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rr_low1 k=%0d got=%b exp=0000", k, gnt); end
         step();
         checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rr_low2 k=%0d got=%b exp=0000", k, gnt); end
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_timeout();
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      step();
      req = 4'b0100;
      for (int c = 1; c <= 15; c++) begin
         step();
         checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_gnt c=%0d got=%b exp=0100", c, gnt); end
         checks++; if (timeout !== 1'(c == 15)) begin failures++; $display("FAIL to_pulse c=%0d got=%b exp=%b", c, timeout, (c == 15)); end
      end
      step();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL to_release got=%b exp=0000", gnt); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_release_pulse got=%b exp=0", timeout); end
      step();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL to_idle got=%b exp=0000", gnt); end
      step();
      checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL to_regrant got=%b exp=0100", gnt); end
      checks++; if (gnt_id !== 2'd2) begin failures++; $display("FAIL to_regrant_id got=%0d exp=2", gnt_id); end
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 4'b0000;
      step();
   endtask

   task automatic test_done_at_max();
      req = 4'b0100;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (c == 15) begin
            done = 1'b1;
            #1;
         end
         checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL dmax_gnt c=%0d got=%b exp=0100", c, gnt); end
         checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL dmax_pulse c=%0d got=%b exp=0", c, timeout); end
      end
      step();
      done = 1'b0;
      req  = 4'b0000;
      #1;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL dmax_release got=%b exp=0000", gnt); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL dmax_release_pulse got=%b exp=0", timeout); end
      step();
   endtask

   task automatic test_reset_mid_grant();
      req = 4'b1000;
      step();
      checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rmid_gnt got=%b exp=1000", gnt); end
      step();
      rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rmid_drop got=%b exp=0000", gnt); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rmid_timeout got=%b exp=0", timeout); end
      checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", gnt_valid); end
      req = 4'b1001;
      step();
      rst_n = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL rmid_post got=%b exp=0000", gnt); end
      step();
      checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rmid_winner got=%b exp=0001", gnt); end
      checks++; if (gnt_id !== 2'd0) begin failures++; $display("FAIL rmid_winner_id got=%0d exp=0", gnt_id); end
      req  = 4'b0000;
      done = 1'b1;
      step();
      done = 1'b0;
      step();
   endtask

   task automatic test_owner_drop();
      req = 4'b0010;
      step();
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL drop_gnt1 got=%b exp=0010", gnt); end
      req = 4'b0110;
      step();
      checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL drop_nonowner got=%b exp=0010", gnt); end
      req = 4'b0100;
      #1;
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL drop_timeout got=%b exp=0", timeout); end
      step();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_release got=%b exp=0000", gnt); end
      req = 4'b0000;
      step();
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_idle got=%b exp=0000", gnt); end
   endtask

   task automatic test_idle_quiet();
      req = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (gnt_valid !== 1'b0) begin failures++; $display("FAIL idle_quiet c=%0d got=%b exp=0", c, gnt_valid); end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_done_at_max();
      test_reset_mid_grant();
      test_owner_drop();
      test_idle_quiet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/file_param_arbiter.md
FILE_PARAM_ARBITER -- requirements
Module: file_param_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the resource (2..8).
REQ-002 Parameter HOLD_MAX, default 15, maximum grant cycles before forced release (1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester request level; bit i belongs to requester i.
REQ-006 done  input  1  current owner finished; sampled only in GRANT.
REQ-007 gnt  output  NUM_REQ  one-hot grant, registered.
REQ-008 gnt_valid  output  1  high whenever gnt is nonzero.
REQ-009 gnt_id  output  clog2(NUM_REQ)  index of the granted requester; 0 when gnt_valid low.
REQ-010 timeout  output  1  single-cycle pulse when a grant is forcibly revoked.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT, RELEASE.
REQ-012 IDLE: if any req bit is high, SHALL go to GRANT next cycle with gnt set to the winner; else stay in IDLE.
REQ-013 Winner SHALL be the first set req bit searching upward from (last_id+1) mod NUM_REQ, wrapping; last_id resets to NUM_REQ-1, so requester 0 has first priority after reset.
REQ-014 Grant latency SHALL be exactly one cycle from req seen in IDLE to gnt high.
REQ-015 On entering GRANT, last_id SHALL update to the winner and hold_cnt SHALL load 1.
REQ-016 GRANT: hold_cnt SHALL increment each cycle, saturating at HOLD_MAX.
REQ-017 GRANT -> RELEASE when done=1, or when the owner's req bit drops to 0; no timeout pulse.
REQ-018 GRANT -> RELEASE with timeout=1 for one cycle when hold_cnt equals HOLD_MAX and neither REQ-017 condition holds.
REQ-019 done and hold_cnt==HOLD_MAX in the same cycle: done wins, timeout stays 0.
REQ-020 RELEASE: gnt SHALL be all-zero for exactly one cycle, then IDLE; req is ignored in RELEASE.
REQ-021 Two consecutive grants SHALL therefore be separated by at least two gnt-low cycles (RELEASE, IDLE).
REQ-022 gnt SHALL never have more than one bit set; gnt_valid SHALL equal the OR of gnt.
REQ-023 req changes on non-owner bits during GRANT SHALL have no effect.

Reset
REQ-024 While rst_n=0: state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0, hold_cnt=0, last_id=NUM_REQ-1.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt immediately (asynchronously), with no timeout pulse.
REQ-026 First grant after rst_n deassertion SHALL follow REQ-012 from IDLE.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, GRANT, RELEASE) and the file-level default constants for NUM_REQ and HOLD_MAX; module parameter defaults SHALL reference them.
REQ-028 The rotating priority search SHALL be a combinational sub-module rr_pick (inputs req, last_id; outputs winner one-hot, winner index, any).
REQ-029 Target size 120-400 lines RTL total, synthesizable by the SystemVerilog frontend without vendor primitives.

Verification
REQ-030 Reset then req=4'b0001, done pulse at grant cycle 3 -> gnt=0001 one cycle after req, RELEASE, then IDLE; timeout never asserted.
REQ-031 req=4'b1111 held, done each grant -> grant order 0,1,2,3,0 with gnt_id matching, two low cycles between grants.
REQ-032 req=4'b0100 held, done never -> gnt=0100 for exactly 15 cycles, timeout pulse on last cycle, then regranted to 2 after IDLE.
REQ-033 done asserted in the cycle hold_cnt==HOLD_MAX -> RELEASE, timeout=0.
REQ-034 rst_n pulled low mid-GRANT with req=4'b1000 -> gnt=0 same cycle; after release requester 0 wins if req=4'b1001.
REQ-035 Owner drops req at grant cycle 2 with no done -> RELEASE next cycle, timeout=0, gnt one-hot throughout (assertion).
